// File: rtl/sim_ctrl_mmio.sv
// sim_ctrl_mmio: memory-mapped simulation control and performance monitor.
// Decodes CPU data-bus stores to a 32-byte window: console bytes go into a
// small FIFO toward a character consumer, a finish command raises a sticky
// fini_o. Four event counters are readable over the same window.
module sim_ctrl_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_8000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] dbus_addr_i,
  input  logic        dbus_we_i,
  input  logic [31:0] dbus_wdata_i,
  input  logic        dbus_re_i,
  output logic [31:0] dbus_rdata_o,
  input  logic        cnt_en_i,
  input  logic        retire_i,
  input  logic        ctrl_tsfr_i,
  input  logic        br_misp_i,
  output logic        char_valid_o,
  output logic [7:0]  char_data_o,
  input  logic        char_ready_i,
  output logic        fini_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    OFF_CMD      = 3'd0,
    OFF_STATUS   = 3'd1,
    OFF_MCYCLE   = 3'd2,
    OFF_MINSTRET = 3'd3,
    OFF_BR_PRED  = 3'd4,
    OFF_BR_MISP  = 3'd5
  } reg_off_e;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_PUTC   = 2'b01,
    CMD_FINISH = 2'b10,
    CMD_CLEAR  = 2'b11
  } cmd_e;

  // Bus decode
  logic       hit;
  logic [2:0] off;
  logic       cmd_wr;
  cmd_e       cmd;

  // FIFO state
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic [7:0]     mem [FIFO_DEPTH];
  logic           fifo_full, fifo_empty;
  logic           push_req, push_ok, pop;
  logic           overflow;

  // Counters
  logic [CNT_W-1:0] mcycle, minstret, br_pred, br_misp;
  logic             cnt_adv, cnt_clear;

  logic [31:0] rd_val;

  assign hit    = (dbus_addr_i[31:5] == BASE_ADDR[31:5]);
  assign off    = dbus_addr_i[4:2];
  assign cmd_wr = dbus_we_i && hit && (off == OFF_CMD);
  assign cmd    = cmd_e'(dbus_wdata_i[17:16]);

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign pop       = !fifo_empty && char_ready_i;
  assign push_req  = cmd_wr && (cmd == CMD_PUTC) && !fini_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = push_req && (!fifo_full || pop);
  assign cnt_adv   = cnt_en_i && !fini_o;
  assign cnt_clear = cmd_wr && (cmd == CMD_CLEAR);

  assign char_valid_o = !fifo_empty;
  assign char_data_o  = fifo_empty ? 8'h00 : mem[rd_ptr[PTR_W-1:0]];

  // FIFO pointers and overflow flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are masked at the output while empty
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= dbus_wdata_i[7:0];
  end

  // Sticky finish request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fini_o <= 1'b0;
    end else if (cmd_wr && (cmd == CMD_FINISH)) begin
      fini_o <= 1'b1;
    end
  end

  // Event counters; clear takes priority over a coincident increment
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcycle   <= '0;
      minstret <= '0;
      br_pred  <= '0;
      br_misp  <= '0;
    end else if (cnt_clear) begin
      mcycle   <= '0;
      minstret <= '0;
      br_pred  <= '0;
      br_misp  <= '0;
    end else if (cnt_adv) begin
      mcycle <= mcycle + CNT_W'(1);
      if (retire_i)                minstret <= minstret + CNT_W'(1);
      if (ctrl_tsfr_i)             br_pred  <= br_pred + CNT_W'(1);
      if (ctrl_tsfr_i && br_misp_i) br_misp <= br_misp + CNT_W'(1);
    end
  end

  // Read mux over pre-update state
  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (off)
        OFF_STATUS:   rd_val = {28'd0, overflow, fini_o, fifo_empty, fifo_full};
        OFF_MCYCLE:   rd_val = 32'(mcycle);
        OFF_MINSTRET: rd_val = 32'(minstret);
        OFF_BR_PRED:  rd_val = 32'(br_pred);
        OFF_BR_MISP:  rd_val = 32'(br_misp);
        default:      rd_val = '0;
      endcase
    end
  end

  // Registered load data, zero when no load was issued
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dbus_rdata_o <= '0;
    end else begin
      dbus_rdata_o <= dbus_re_i ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_sim_ctrl_mmio.sv
// Bench for sim_ctrl_mmio: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized phase.
module tb_sim_ctrl_mmio;

  localparam logic [31:0] BASE  = 32'h4000_8000;
  localparam int          DEPTH = 4;
  localparam longint      MASK  = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic        re = 1'b0;
  logic        cnt_en = 1'b0, retire = 1'b0, ctrl = 1'b0, misp = 1'b0;
  logic        ready = 1'b0;

  logic [31:0] rdata, rdata8;
  logic        cv, cv8, fini, fini8;
  logic [7:0]  cd, cd8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sim_ctrl_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .CNT_W(32)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .dbus_addr_i(addr), .dbus_we_i(we), .dbus_wdata_i(wdata),
    .dbus_re_i(re), .dbus_rdata_o(rdata),
    .cnt_en_i(cnt_en), .retire_i(retire), .ctrl_tsfr_i(ctrl), .br_misp_i(misp),
    .char_valid_o(cv), .char_data_o(cd), .char_ready_i(ready), .fini_o(fini)
  );

  // Narrow-counter instance used to reach the wrap point in a short run.
  sim_ctrl_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .CNT_W(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n),
    .dbus_addr_i(addr), .dbus_we_i(we), .dbus_wdata_i(wdata),
    .dbus_re_i(re), .dbus_rdata_o(rdata8),
    .cnt_en_i(cnt_en), .retire_i(retire), .ctrl_tsfr_i(ctrl), .br_misp_i(misp),
    .char_valid_o(cv8), .char_data_o(cd8), .char_ready_i(ready), .fini_o(fini8)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mq[$];
  bit          m_fini = 0;
  bit          m_ovf = 0;
  longint      m_cnt[4] = '{0, 0, 0, 0};
  logic [31:0] m_rdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_fini = 0;
      m_ovf = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_rdata = '0;
    end else begin
      bit          is_hit;
      int          o;
      logic [31:0] nxt;
      bit          do_fin, do_clr;
      is_hit = (addr[31:5] == BASE[31:5]);
      o      = int'(addr[4:2]);
      nxt    = '0;
      if (re && is_hit) begin
        if (o == 1)
          nxt = {28'd0, m_ovf, m_fini, (mq.size() == 0), (mq.size() == DEPTH)};
        else if (o >= 2 && o <= 5)
          nxt = 32'(m_cnt[o-2]);
      end
      if (mq.size() > 0 && ready) void'(mq.pop_front());
      do_fin = 0;
      do_clr = 0;
      if (we && is_hit && o == 0) begin
        case (wdata[17:16])
          2'b01: if (!m_fini) begin
                   if (mq.size() < DEPTH) mq.push_back(wdata[7:0]);
                   else m_ovf = 1;
                 end
          2'b10: do_fin = 1;
          2'b11: do_clr = 1;
          default: ;
        endcase
      end
      if (do_clr) begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
      end else if (cnt_en && !m_fini) begin
        m_cnt[0] = (m_cnt[0] + 1) & MASK;
        if (retire)         m_cnt[1] = (m_cnt[1] + 1) & MASK;
        if (ctrl)           m_cnt[2] = (m_cnt[2] + 1) & MASK;
        if (ctrl && misp)   m_cnt[3] = (m_cnt[3] + 1) & MASK;
      end
      if (do_fin) m_fini = 1;
      m_rdata = nxt;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("char_valid", {31'd0, cv}, {31'd0, (mq.size() != 0)});
    chk("char_data", {24'd0, cd}, (mq.size() != 0) ? {24'd0, mq[0]} : 32'd0);
    chk("fini", {31'd0, fini}, {31'd0, m_fini});
    chk("rdata", rdata, m_rdata);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] e32,
                      input logic [31:0] e8, input string nm);
    addr = a; re = 1'b1;
    tick();
    re = 1'b0; addr = '0;
    @(negedge clk);
    chk(nm, rdata, e32);
    chk({nm, "_w8"}, rdata8, e8);
  endtask

  task automatic idle_inputs();
    cnt_en = 0; retire = 0; ctrl = 0; misp = 0; ready = 0;
    we = 0; re = 0; addr = '0; wdata = '0;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_valid", {31'd0, cv}, 32'd0);
    chk("reset_fini", {31'd0, fini}, 32'd0);

    // Single putchar, then drain
    store(BASE, 32'h0001_0041);
    chk("putc_valid", {31'd0, cv}, 32'd1);
    chk("putc_data", {24'd0, cd}, 32'h41);
    ready = 1;
    tick();
    chk("putc_drained", {31'd0, cv}, 32'd0);
    ready = 0;

    // Asynchronous reset with bytes queued and counters running
    cnt_en = 1; retire = 1; ctrl = 1;
    store(BASE, 32'h0001_0078);
    store(BASE, 32'h0001_0079);
    store(BASE, 32'h0001_007A);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, cv}, 32'd0);
    chk("midrst_fini", {31'd0, fini}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    load(BASE + 32'h08, 32'd0, 32'd0, "rst_mcycle");
    load(BASE + 32'h0C, 32'd0, 32'd0, "rst_minstret");
    load(BASE + 32'h10, 32'd0, 32'd0, "rst_br_pred");
    load(BASE + 32'h14, 32'd0, 32'd0, "rst_br_misp");

    // Overflow: five pushes into a depth-4 FIFO
    for (int i = 0; i < 5; i++) store(BASE, 32'h0001_0041 + i);
    load(BASE + 32'h04, 32'h9, 32'h9, "ovf_status");
    ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", {31'd0, cv}, 32'd1);
      chk("drain_data", {24'd0, cd}, 32'h41 + i);
      tick();
    end
    chk("drain_empty", {31'd0, cv}, 32'd0);
    ready = 0;

    // Cycle and retire counters, then a clear racing a retire
    store(BASE, 32'h0003_0000);
    for (int i = 0; i < 10; i++) begin
      cnt_en = 1; retire = (i < 6);
      tick();
    end
    cnt_en = 0; retire = 0;
    load(BASE + 32'h08, 32'd10, 32'd10, "mcycle10");
    load(BASE + 32'h0C, 32'd6, 32'd6, "minstret6");
    cnt_en = 1; retire = 1;
    store(BASE, 32'h0003_0000);
    cnt_en = 0; retire = 0;
    load(BASE + 32'h08, 32'd0, 32'd0, "clr_mcycle");
    load(BASE + 32'h0C, 32'd0, 32'd0, "clr_minstret");

    // Branch counters; mispredict ignored without a control transfer
    for (int i = 0; i < 10; i++) begin
      cnt_en = 1; ctrl = (i < 8); misp = (i < 3) || (i >= 8);
      tick();
    end
    cnt_en = 0; ctrl = 0; misp = 0;
    load(BASE + 32'h10, 32'd8, 32'd8, "br_pred8");
    load(BASE + 32'h14, 32'd3, 32'd3, "br_misp3");

    // Randomized traffic, finish excluded so the FIFO stays live
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [31:0] d;
      cnt_en = ($urandom_range(0, 3) != 0);
      retire = $urandom_range(0, 1) == 1;
      ctrl   = $urandom_range(0, 1) == 1;
      misp   = $urandom_range(0, 1) == 1;
      ready  = ($urandom_range(0, 2) == 0);
      we     = ($urandom_range(0, 2) == 0);
      re     = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) != 0) begin
        addr = BASE + (($urandom_range(0, 1) == 1) ? 32'd0 : (32'($urandom_range(0, 7)) << 2))
                    + 32'($urandom_range(0, 3));
      end else begin
        addr = BASE ^ (32'd1 << $urandom_range(5, 31));
      end
      r = $urandom_range(0, 15);
      d = $urandom;
      d[17:16] = (r == 0) ? 2'b11 : (r < 4) ? 2'b00 : 2'b01;
      wdata = d;
      tick();
    end
    idle_inputs();
    tick();

    // Counter wrap on the 8-bit instance
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    cnt_en = 1;
    repeat (255) tick();
    cnt_en = 0;
    load(BASE + 32'h08, 32'd255, 32'hFF, "mcycle_allones");
    cnt_en = 1;
    tick();
    cnt_en = 0;
    load(BASE + 32'h08, 32'd256, 32'd0, "mcycle_wrap");

    // Finish: counters freeze, putchar ignored, status reflects fini
    store(BASE, 32'h0003_0000);
    cnt_en = 1;
    repeat (5) tick();
    cnt_en = 0;
    store(BASE, 32'h0002_0000);
    chk("fini_set", {31'd0, fini}, 32'd1);
    cnt_en = 1; retire = 1; ctrl = 1; misp = 1;
    repeat (20) tick();
    idle_inputs();
    load(BASE + 32'h08, 32'd5, 32'd5, "frozen_mcycle");
    load(BASE + 32'h0C, 32'd0, 32'd0, "frozen_minstret");
    load(BASE + 32'h10, 32'd0, 32'd0, "frozen_br_pred");
    store(BASE, 32'h0001_0055);
    chk("fini_no_push", {31'd0, cv}, 32'd0);
    load(BASE + 32'h04, 32'h6, 32'h6, "fini_status");
    store(BASE, 32'h0002_0000);
    chk("fini_repeat", {31'd0, fini}, 32'd1);
    load(BASE + 32'h18, 32'd0, 32'd0, "off6_zero");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
